parking_gate_controller: RTL
============================

// Module: parking_gate_controller
// PURPOSE
//  Sequencer for the parking-lot datapath: arbitrates car entry/exit requests, owns the spot
//  occupancy vector, allocates the lowest-numbered free spot and times the barrier gate.
//  occupancy[] drives new_capacity of parking_capacity_counter, so parked/empty displays stay in step.
//  One request is serviced at a time; the gate is a single shared resource.
// PARAMETERS
//  N_SPOTS          8   number of spots (2..15); occupancy width
//  GATE_OPEN_CYCLES 4   cycles gate_open stays high per serviced car (>=1)
//  localparam SPOT_W = $clog2(N_SPOTS), CNT_W = $clog2(N_SPOTS+1)
// PORTS
//  clk            in   1        system clock, rising edge
//  reset          in   1        synchronous, active-high
//  entry_req      in   1        car at entry sensor (level, held until serviced)
//  exit_req       in   1        car at exit sensor (level, held until serviced)
//  exit_spot      in   SPOT_W   spot being vacated, valid with exit_req
//  entry_grant    out  1        1-cycle pulse: entry accepted
//  entry_reject   out  1        1-cycle pulse: entry refused, lot full
//  exit_error     out  1        1-cycle pulse: exit_spot not occupied or >= N_SPOTS
//  assigned_spot  out  SPOT_W   spot given to last accepted car; holds until next grant
//  gate_open      out  1        barrier raised
//  occupancy      out  N_SPOTS  bit i = 1 -> spot i occupied
//  parked_count   out  CNT_W    popcount(occupancy), registered
//  full           out  1        parked_count == N_SPOTS
// BEHAVIOUR
//  Reset: all outputs 0, occupancy all-free, state IDLE; reset mid-gate drops gate_open next edge
//   and clears occupancy (lot re-inventoried by software/test).
//  States: IDLE, ENTRY_GATE, EXIT_GATE, HOLD.
//  IDLE, evaluated each edge:
//   - exit_req=1 and exit valid (spot < N_SPOTS, occupied): clear bit, -> EXIT_GATE.
//   - exit_req=1 and invalid: exit_error pulse, -> HOLD (no state change to occupancy).
//   - else entry_req=1 and !full: set lowest free bit, assigned_spot<=that index,
//     entry_grant pulse, -> ENTRY_GATE.
//   - else entry_req=1 and full: entry_reject pulse, -> HOLD.
//   - Simultaneous entry+exit: exit wins (frees space); entry serviced after exit completes.
//  ENTRY_GATE/EXIT_GATE: gate_open=1 for exactly GATE_OPEN_CYCLES cycles starting the cycle after
//   the accepting edge; then -> HOLD. Requests ignored while gate open.
//  HOLD: wait until the serviced request input deasserts (entry_req for entry/reject, exit_req for
//   exit/error), then -> IDLE. Prevents double-service of a held level.
//  Latency: request sampled in IDLE -> grant/reject/error pulse and occupancy update visible 1 cycle
//   later; parked_count/full update same cycle as occupancy.
//  parked_count never exceeds N_SPOTS and never underflows; full is combinational-free (registered).
//  Allocation: priority encoder, lowest index wins; freed spots are reused.
// TESTING
//  1 reset, entry_req held 1 -> entry_grant pulse, assigned_spot=0, occupancy=8'b00000001,
//    gate_open high 4 cycles, no second grant until entry_req drops.
//  2 fill all 8 spots (8 entry cycles) -> assigned_spot 0..7, full=1, parked_count=8; 9th entry ->
//    entry_reject pulse, occupancy unchanged 8'hFF.
//  3 from 8'hFF, exit_req with exit_spot=3 -> occupancy=8'hF7, count 7, gate_open 4 cycles; next
//    entry -> assigned_spot=3.
//  4 entry_req and exit_req(spot 0) same edge with occupancy 8'h01 -> exit serviced first
//    (occupancy 8'h00), after release entry granted spot 0.
//  5 exit_req with unoccupied exit_spot=5 -> exit_error pulse, occupancy/count unchanged, no gate.
//  6 reset asserted during gate_open with occupancy 8'h0F -> next cycle gate_open=0, occupancy=0,
//    parked_count=0, state IDLE.

Source files
------------

// File: rtl/parking_gate_controller.sv
// Parking-lot sequencer: arbitrates entry/exit requests, owns the spot occupancy vector,
// allocates the lowest free spot and times the shared barrier gate.
module parking_gate_controller #(
    parameter int N_SPOTS          = 8,
    parameter int GATE_OPEN_CYCLES = 4,
    localparam int SPOT_W          = $clog2(N_SPOTS),
    localparam int CNT_W           = $clog2(N_SPOTS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              entry_req,
    input  logic              exit_req,
    input  logic [SPOT_W-1:0] exit_spot,
    output logic              entry_grant,
    output logic              entry_reject,
    output logic              exit_error,
    output logic [SPOT_W-1:0] assigned_spot,
    output logic              gate_open,
    output logic [N_SPOTS-1:0] occupancy,
    output logic [CNT_W-1:0]  parked_count,
    output logic              full
);

    localparam int GATE_W = (GATE_OPEN_CYCLES > 1) ? $clog2(GATE_OPEN_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ENTRY_GATE = 2'd1,
        EXIT_GATE  = 2'd2,
        HOLD       = 2'd3
    } state_t;

    state_t              state, state_next;
    logic [GATE_W-1:0]   gate_cnt, gate_cnt_next;
    logic                hold_exit, hold_exit_next;
    logic [N_SPOTS-1:0]  occupancy_next;
    logic [SPOT_W-1:0]   assigned_spot_next;
    logic [CNT_W-1:0]    parked_count_next;
    logic                grant_next, reject_next, error_next;

    function automatic logic [SPOT_W-1:0] lowest_free(input logic [N_SPOTS-1:0] occ);
        logic [SPOT_W-1:0] idx;
        idx = '0;
        for (int i = N_SPOTS - 1; i >= 0; i--) begin
            if (!occ[i]) idx = SPOT_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [N_SPOTS-1:0] spot_mask(input logic [SPOT_W-1:0] spot);
        logic [N_SPOTS-1:0] m;
        m = '0;
        for (int i = 0; i < N_SPOTS; i++) begin
            if (SPOT_W'(i) == spot) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Out-of-range spot numbers never match any mask bit, so they read as unoccupied.
    function automatic logic is_occupied(input logic [N_SPOTS-1:0] occ,
                                         input logic [SPOT_W-1:0]  spot);
        return |(occ & spot_mask(spot));
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [N_SPOTS-1:0] occ);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_SPOTS; i++) c = c + CNT_W'(occ[i]);
        return c;
    endfunction

    always_comb begin
        state_next         = state;
        gate_cnt_next      = gate_cnt;
        hold_exit_next     = hold_exit;
        occupancy_next     = occupancy;
        assigned_spot_next = assigned_spot;
        grant_next         = 1'b0;
        reject_next        = 1'b0;
        error_next         = 1'b0;
        case (state)
            IDLE: begin
                gate_cnt_next = '0;
                // Exit wins a tie: it frees space that the waiting entry may then use.
                if (exit_req) begin
                    hold_exit_next = 1'b1;
                    if (is_occupied(occupancy, exit_spot)) begin
                        occupancy_next = occupancy & ~spot_mask(exit_spot);
                        state_next     = EXIT_GATE;
                    end else begin
                        error_next = 1'b1;
                        state_next = HOLD;
                    end
                end else if (entry_req) begin
                    hold_exit_next = 1'b0;
                    if (!full) begin
                        occupancy_next     = occupancy | spot_mask(lowest_free(occupancy));
                        assigned_spot_next = lowest_free(occupancy);
                        grant_next         = 1'b1;
                        state_next         = ENTRY_GATE;
                    end else begin
                        reject_next = 1'b1;
                        state_next  = HOLD;
                    end
                end
            end
            ENTRY_GATE, EXIT_GATE: begin
                if (gate_cnt == GATE_W'(GATE_OPEN_CYCLES - 1)) begin
                    state_next = HOLD;
                end else begin
                    gate_cnt_next = gate_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (hold_exit ? !exit_req : !entry_req) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        parked_count_next = popcount(occupancy_next);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            gate_cnt      <= '0;
            hold_exit     <= 1'b0;
            occupancy     <= '0;
            assigned_spot <= '0;
            parked_count  <= '0;
            full          <= 1'b0;
            entry_grant   <= 1'b0;
            entry_reject  <= 1'b0;
            exit_error    <= 1'b0;
        end else begin
            state         <= state_next;
            gate_cnt      <= gate_cnt_next;
            hold_exit     <= hold_exit_next;
            occupancy     <= occupancy_next;
            assigned_spot <= assigned_spot_next;
            parked_count  <= parked_count_next;
            full          <= (parked_count_next == CNT_W'(N_SPOTS));
            entry_grant   <= grant_next;
            entry_reject  <= reject_next;
            exit_error    <= error_next;
        end
    end

    assign gate_open = (state == ENTRY_GATE) || (state == EXIT_GATE);

endmodule
